// File: rtl/issue_queue_param.sv
// Unified issue queue: captures operands from ARF/ROB/CDB, wakes up on CDB,
// issues up to ISSUE_W ready entries per cycle oldest first.
// Ports: clk, rst_n, flush, stall_in; dispatch in_*; arf_*/rob_* operand
// sources; cdb_* wakeup channels; fu_* registered issue ports; iq_stall, count.
module issue_queue_param #(
    parameter int DEPTH   = 16,
    parameter int ISSUE_W = 3,
    parameter int CDB_N   = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        stall_in,
    input  logic                        in_valid,
    input  logic [OP_W-1:0]             in_op,
    input  logic [TAG_W-1:0]            in_tag_rd,
    input  logic [TAG_W-1:0]            in_rob_index,
    input  logic [TAG_W-1:0]            in_tag_rs1,
    input  logic [TAG_W-1:0]            in_tag_rs2,
    input  logic                        in_use_imm,
    input  logic [DATA_W-1:0]           in_imm,
    input  logic                        in_loadstore,
    input  logic [DATA_W-1:0]           arf_rs1_data,
    input  logic [DATA_W-1:0]           arf_rs2_data,
    input  logic [1:0]                  rob_contains,
    input  logic [1:0]                  rob_ready,
    input  logic [2*DATA_W-1:0]         rob_data,
    input  logic [CDB_N-1:0]            cdb_valid,
    input  logic [CDB_N*TAG_W-1:0]      cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]     cdb_data,
    output logic [ISSUE_W-1:0]          fu_valid,
    output logic [ISSUE_W*OP_W-1:0]     fu_op,
    output logic [ISSUE_W*DATA_W-1:0]   fu_rs1,
    output logic [ISSUE_W*DATA_W-1:0]   fu_rs2,
    output logic [ISSUE_W*TAG_W-1:0]    fu_tag,
    output logic [ISSUE_W*TAG_W-1:0]    fu_rob_index,
    output logic [ISSUE_W-1:0]          fu_loadstore,
    output logic                        iq_stall,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int RW = IW + 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  rd;
        logic [TAG_W-1:0]  rob;
        logic              ls;
        logic              r1;
        logic [TAG_W-1:0]  t1;
        logic [DATA_W-1:0] d1;
        logic              r2;
        logic [TAG_W-1:0]  t2;
        logic [DATA_W-1:0] d2;
    } entry_t;

    // Returns {hit, data}; scanning downward lets the lowest channel win.
    function automatic logic [DATA_W:0] cdb_match(
        input logic [TAG_W-1:0]        t,
        input logic [CDB_N-1:0]        v,
        input logic [CDB_N*TAG_W-1:0]  tg,
        input logic [CDB_N*DATA_W-1:0] d
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (v[k] && tg[k*TAG_W +: TAG_W] == t) begin
                r = {1'b1, d[k*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    logic [DEPTH-1:0]             valid;
    entry_t                       ent [DEPTH];
    // age[i][j] set: entry j is older than entry i
    logic [DEPTH-1:0][DEPTH-1:0]  age;

    logic                         has_free;
    logic [IW-1:0]                free_idx;
    logic                         acc;
    entry_t                       new_e;
    logic [DATA_W:0]              m1;
    logic [DATA_W:0]              m2;
    logic [DATA_W:0]              wk1 [DEPTH];
    logic [DATA_W:0]              wk2 [DEPTH];
    logic [DEPTH-1:0]             rdy;
    logic [RW-1:0]                rank [DEPTH];
    logic [ISSUE_W-1:0]           pv;
    logic [IW-1:0]                pidx [ISSUE_W];
    logic [DEPTH-1:0]             issue_mask;
    logic [CW-1:0]                issued;

    assign iq_stall = (count == CW'(DEPTH));
    assign acc      = in_valid & ~iq_stall & ~flush & has_free;

    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign m1 = cdb_match(in_tag_rs1, cdb_valid, cdb_tag, cdb_data);
    assign m2 = cdb_match(in_tag_rs2, cdb_valid, cdb_tag, cdb_data);

    always_comb begin
        new_e     = '0;
        new_e.op  = in_op;
        new_e.rd  = in_tag_rd;
        new_e.rob = in_rob_index;
        new_e.ls  = in_loadstore;
        new_e.t1  = in_tag_rs1;
        new_e.t2  = in_tag_rs2;
        if (!rob_contains[0]) begin
            new_e.r1 = 1'b1;
            new_e.d1 = arf_rs1_data;
        end else if (rob_ready[0]) begin
            new_e.r1 = 1'b1;
            new_e.d1 = rob_data[DATA_W-1:0];
        end else if (m1[DATA_W]) begin
            new_e.r1 = 1'b1;
            new_e.d1 = m1[DATA_W-1:0];
        end
        if (in_use_imm) begin
            new_e.r2 = 1'b1;
            new_e.d2 = in_imm;
        end else if (!rob_contains[1]) begin
            new_e.r2 = 1'b1;
            new_e.d2 = arf_rs2_data;
        end else if (rob_ready[1]) begin
            new_e.r2 = 1'b1;
            new_e.d2 = rob_data[2*DATA_W-1:DATA_W];
        end else if (m2[DATA_W]) begin
            new_e.r2 = 1'b1;
            new_e.d2 = m2[DATA_W-1:0];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk1[i] = cdb_match(ent[i].t1, cdb_valid, cdb_tag, cdb_data);
            wk2[i] = cdb_match(ent[i].t2, cdb_valid, cdb_tag, cdb_data);
            rdy[i] = valid[i] & ent[i].r1 & ent[i].r2;
        end
    end

    // An entry's rank is the number of ready entries older than it;
    // rank p routes to port p, so the oldest ready entry lands on port 0.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rank[i] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                rank[i] = rank[i] + RW'(rdy[j] & age[i][j]);
            end
        end
    end

    always_comb begin
        pv         = '0;
        issue_mask = '0;
        issued     = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            pidx[p] = '0;
        end
        if (!stall_in && !flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int p = 0; p < ISSUE_W; p++) begin
                    if (rdy[i] && rank[i] == RW'(p)) begin
                        pv[p]         = 1'b1;
                        pidx[p]       = IW'(i);
                        issue_mask[i] = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            issued = issued + CW'(issue_mask[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid        <= '0;
            age          <= '0;
            count        <= '0;
            fu_valid     <= '0;
            fu_op        <= '0;
            fu_rs1       <= '0;
            fu_rs2       <= '0;
            fu_tag       <= '0;
            fu_rob_index <= '0;
            fu_loadstore <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else if (flush) begin
            valid    <= '0;
            age      <= '0;
            count    <= '0;
            fu_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && !ent[i].r1 && wk1[i][DATA_W]) begin
                    ent[i].r1 <= 1'b1;
                    ent[i].d1 <= wk1[i][DATA_W-1:0];
                end
                if (valid[i] && !ent[i].r2 && wk2[i][DATA_W]) begin
                    ent[i].r2 <= 1'b1;
                    ent[i].d2 <= wk2[i][DATA_W-1:0];
                end
            end
            valid <= (valid & ~issue_mask)
                   | (acc ? (DEPTH'(1) << free_idx) : '0);
            if (acc) begin
                ent[free_idx] <= new_e;
                age[free_idx] <= valid;
                for (int i = 0; i < DEPTH; i++) begin
                    age[i][free_idx] <= 1'b0;
                end
            end
            for (int p = 0; p < ISSUE_W; p++) begin
                fu_valid[p] <= pv[p];
                if (pv[p]) begin
                    fu_op[p*OP_W +: OP_W]          <= ent[pidx[p]].op;
                    fu_rs1[p*DATA_W +: DATA_W]     <= ent[pidx[p]].d1;
                    fu_rs2[p*DATA_W +: DATA_W]     <= ent[pidx[p]].d2;
                    fu_tag[p*TAG_W +: TAG_W]       <= ent[pidx[p]].rd;
                    fu_rob_index[p*TAG_W +: TAG_W] <= ent[pidx[p]].rob;
                    fu_loadstore[p]                <= ent[pidx[p]].ls;
                end
            end
            count <= count + CW'(acc) - issued;
        end
    end

endmodule

// File: tb/tb_issue_queue_param.sv
// Scoreboard bench for issue_queue_param: directed dispatch/wakeup vectors,
// expected issues queued with their cycle and checked by a negedge monitor.
module tb_issue_queue_param;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         stall_in;
    logic         in_valid;
    logic [3:0]   in_op;
    logic [5:0]   in_tag_rd;
    logic [5:0]   in_rob_index;
    logic [5:0]   in_tag_rs1;
    logic [5:0]   in_tag_rs2;
    logic         in_use_imm;
    logic [31:0]  in_imm;
    logic         in_loadstore;
    logic [31:0]  arf_rs1_data;
    logic [31:0]  arf_rs2_data;
    logic [1:0]   rob_contains;
    logic [1:0]   rob_ready;
    logic [63:0]  rob_data;
    logic [3:0]   cdb_valid;
    logic [23:0]  cdb_tag;
    logic [127:0] cdb_data;
    logic [2:0]   fu_valid;
    logic [11:0]  fu_op;
    logic [95:0]  fu_rs1;
    logic [95:0]  fu_rs2;
    logic [17:0]  fu_tag;
    logic [17:0]  fu_rob_index;
    logic [2:0]   fu_loadstore;
    logic         iq_stall;
    logic [4:0]   count;

    issue_queue_param dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall_in(stall_in),
        .in_valid(in_valid), .in_op(in_op), .in_tag_rd(in_tag_rd),
        .in_rob_index(in_rob_index), .in_tag_rs1(in_tag_rs1),
        .in_tag_rs2(in_tag_rs2), .in_use_imm(in_use_imm),
        .in_imm(in_imm), .in_loadstore(in_loadstore),
        .arf_rs1_data(arf_rs1_data), .arf_rs2_data(arf_rs2_data),
        .rob_contains(rob_contains), .rob_ready(rob_ready),
        .rob_data(rob_data), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .fu_valid(fu_valid), .fu_op(fu_op),
        .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_tag(fu_tag),
        .fu_rob_index(fu_rob_index), .fu_loadstore(fu_loadstore),
        .iq_stall(iq_stall), .count(count)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [1:0]  port;
        logic [3:0]  op;
        logic [5:0]  tag;
        logic [5:0]  rob;
        logic        ls;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   mark;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < 3; p++) begin
                if (fu_valid[p]) begin
                    exp_t e;
                    exp_t g;
                    total++;
                    if (sbq.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_issue port=%0d tag=%0d cyc=%0d",
                                 p, fu_tag[p*6 +: 6], cyc);
                    end else begin
                        e = sbq.pop_front();
                        g.cyc  = cyc;
                        g.port = 2'(p);
                        g.op   = fu_op[p*4 +: 4];
                        g.tag  = fu_tag[p*6 +: 6];
                        g.rob  = fu_rob_index[p*6 +: 6];
                        g.ls   = fu_loadstore[p];
                        g.rs1  = fu_rs1[p*32 +: 32];
                        g.rs2  = fu_rs2[p*32 +: 32];
                        if (g !== e) begin
                            bad++;
                            $display("FAIL issue got cyc=%0d port=%0d op=%0d tag=%0d rob=%0d ls=%0d rs1=%0h rs2=%0h exp cyc=%0d port=%0d op=%0d tag=%0d rob=%0d ls=%0d rs1=%0h rs2=%0h",
                                     g.cyc, g.port, g.op, g.tag, g.rob, g.ls, g.rs1, g.rs2,
                                     e.cyc, e.port, e.op, e.tag, e.rob, e.ls, e.rs1, e.rs2);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        in_valid     = 1'b0;
        in_op        = '0;
        in_tag_rd    = '0;
        in_rob_index = '0;
        in_tag_rs1   = '0;
        in_tag_rs2   = '0;
        in_use_imm   = 1'b0;
        in_imm       = '0;
        in_loadstore = 1'b0;
        arf_rs1_data = '0;
        arf_rs2_data = '0;
        rob_contains = '0;
        rob_ready    = '0;
        rob_data     = '0;
        cdb_valid    = '0;
        cdb_tag      = '0;
        cdb_data     = '0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [5:0] rd,
                        input logic [31:0] a1, input logic [31:0] a2);
        clr();
        in_valid     = 1'b1;
        in_op        = op;
        in_tag_rd    = rd;
        in_rob_index = rd ^ 6'h20;
        arf_rs1_data = a1;
        arf_rs2_data = a2;
    endtask

    task automatic cdb(input int k, input logic [5:0] t,
                       input logic [31:0] d);
        cdb_valid[k]         = 1'b1;
        cdb_tag[k*6 +: 6]    = t;
        cdb_data[k*32 +: 32] = d;
    endtask

    task automatic push(input int port, input logic [3:0] op,
                        input logic [5:0] rd, input logic [31:0] r1,
                        input logic [31:0] r2, input logic ls,
                        input int at);
        exp_t e;
        e.cyc  = at;
        e.port = 2'(port);
        e.op   = op;
        e.tag  = rd;
        e.rob  = rd ^ 6'h20;
        e.ls   = ls;
        e.rs1  = r1;
        e.rs2  = r2;
        sbq.push_back(e);
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        stall_in = 1'b0;
        disp(4'd1, 6'd1, 32'd5, 32'd7);
        repeat (3) tick();
        chk("reset_count", 32'(count), 0);
        chk("reset_fu_valid", 32'(fu_valid), 0);
        rst_n = 1'b1;
        clr();
        tick();
        tick();
        chk("post_reset_count", 32'(count), 0);
        chk("post_reset_stall", 32'(iq_stall), 0);
        chk("post_reset_fu_valid", 32'(fu_valid), 0);

        // three ready dispatches held back, then issued together
        stall_in = 1'b1;
        disp(4'd1, 6'd1, 32'd5, 32'd7);
        tick();
        disp(4'd2, 6'd2, 32'd5, 32'd7);
        tick();
        disp(4'd3, 6'd3, 32'd5, 32'd7);
        mark = cyc;
        push(0, 4'd1, 6'd1, 32'd5, 32'd7, 1'b0, mark + 2);
        push(1, 4'd2, 6'd2, 32'd5, 32'd7, 1'b0, mark + 2);
        push(2, 4'd3, 6'd3, 32'd5, 32'd7, 1'b0, mark + 2);
        tick();
        clr();
        chk("three_resident", 32'(count), 3);
        stall_in = 1'b0;
        tick();
        chk("three_issued_count", 32'(count), 0);
        tick();

        // rs1 waits on tag 12, woken by CDB channel 1
        disp(4'd4, 6'd10, 32'd0, 32'd7);
        in_tag_rs1   = 6'd12;
        rob_contains = 2'b01;
        tick();
        clr();
        tick();
        cdb(0, 6'd13, 32'h1111);
        cdb(1, 6'd12, 32'hDEAD);
        push(0, 4'd4, 6'd10, 32'hDEAD, 32'd7, 1'b0, cyc + 2);
        tick();
        clr();
        tick();
        tick();

        // same-cycle CDB bypass at dispatch, lowest channel wins
        disp(4'd5, 6'd11, 32'd0, 32'd7);
        in_tag_rs1   = 6'd12;
        rob_contains = 2'b01;
        cdb(1, 6'd12, 32'hBEEF);
        cdb(2, 6'd12, 32'h0BAD);
        push(0, 4'd5, 6'd11, 32'hBEEF, 32'd7, 1'b0, cyc + 2);
        tick();
        clr();
        tick();
        tick();

        // rs2 waits on load channel; duplicate tag, lower channel wins
        disp(4'd6, 6'd12, 32'd1, 32'd0);
        in_tag_rs2   = 6'd33;
        rob_contains = 2'b10;
        in_loadstore = 1'b1;
        tick();
        clr();
        cdb(2, 6'd33, 32'hF00D);
        cdb(3, 6'd33, 32'hCAFE);
        push(0, 4'd6, 6'd12, 32'd1, 32'hF00D, 1'b1, cyc + 2);
        tick();
        clr();
        tick();
        tick();

        // fill all 16 entries waiting on tag 9
        for (int i = 0; i < 16; i++) begin
            disp(4'd7, 6'(i), 32'd0, 32'(i));
            in_tag_rs1   = 6'd9;
            rob_contains = 2'b01;
            tick();
        end
        clr();
        chk("full_count", 32'(count), 16);
        chk("full_stall", 32'(iq_stall), 1);
        disp(4'd7, 6'd50, 32'd0, 32'd0);
        tick();
        clr();
        chk("drop_count", 32'(count), 16);
        cdb(0, 6'd9, 32'h99);
        mark = cyc;
        for (int i = 0; i < 16; i++) begin
            push(i % 3, 4'd7, 6'(i), 32'h99, 32'(i), 1'b0,
                 mark + 2 + i / 3);
        end
        tick();
        clr();
        tick();
        chk("after_first_issue_count", 32'(count), 13);
        chk("after_first_issue_stall", 32'(iq_stall), 0);
        repeat (6) tick();
        chk("drained_count", 32'(count), 0);

        // age order: waiting A skipped, B/C/D issue in order
        stall_in = 1'b1;
        disp(4'd8, 6'd40, 32'd0, 32'd0);
        in_tag_rs1   = 6'd3;
        rob_contains = 2'b01;
        tick();
        disp(4'd8, 6'd41, 32'd2, 32'd2);
        tick();
        disp(4'd9, 6'd42, 32'd3, 32'd0);
        in_use_imm = 1'b1;
        in_imm     = 32'd100;
        tick();
        disp(4'd10, 6'd43, 32'd0, 32'd0);
        rob_contains = 2'b11;
        rob_ready    = 2'b11;
        rob_data     = {32'd44, 32'd43};
        mark = cyc;
        push(0, 4'd8, 6'd41, 32'd2, 32'd2, 1'b0, mark + 2);
        push(1, 4'd9, 6'd42, 32'd3, 32'd100, 1'b0, mark + 2);
        push(2, 4'd10, 6'd43, 32'd43, 32'd44, 1'b0, mark + 2);
        tick();
        clr();
        stall_in = 1'b0;
        tick();
        // G ready, F waits on tag 4; G drains, H reuses a lower slot
        stall_in = 1'b1;
        disp(4'd11, 6'd45, 32'd6, 32'd6);
        tick();
        disp(4'd12, 6'd46, 32'd0, 32'd6);
        in_tag_rs1   = 6'd4;
        rob_contains = 2'b01;
        tick();
        clr();
        stall_in = 1'b0;
        push(0, 4'd11, 6'd45, 32'd6, 32'd6, 1'b0, cyc + 1);
        tick();
        stall_in = 1'b1;
        disp(4'd13, 6'd47, 32'd8, 32'd8);
        tick();
        clr();
        cdb(0, 6'd3, 32'hAAAA);
        cdb(1, 6'd4, 32'hBBBB);
        mark = cyc;
        push(0, 4'd8, 6'd40, 32'hAAAA, 32'd0, 1'b0, mark + 2);
        push(1, 4'd12, 6'd46, 32'hBBBB, 32'd6, 1'b0, mark + 2);
        push(2, 4'd13, 6'd47, 32'd8, 32'd8, 1'b0, mark + 2);
        tick();
        clr();
        stall_in = 1'b0;
        tick();
        tick();
        chk("age_drained_count", 32'(count), 0);

        // stall holds five ready entries, then flush discards them
        stall_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            disp(4'd14, 6'(60 + i), 32'(i), 32'(i));
            tick();
        end
        clr();
        tick();
        tick();
        chk("stall_count", 32'(count), 5);
        chk("stall_fu_valid", 32'(fu_valid), 0);
        flush    = 1'b1;
        stall_in = 1'b0;
        disp(4'd15, 6'd20, 32'd1, 32'd1);
        tick();
        flush = 1'b0;
        clr();
        chk("flush_count", 32'(count), 0);
        chk("flush_fu_valid", 32'(fu_valid), 0);
        repeat (4) tick();
        chk("post_flush_count", 32'(count), 0);

        // async reset mid-operation
        stall_in = 1'b1;
        disp(4'd1, 6'd21, 32'd1, 32'd1);
        tick();
        disp(4'd1, 6'd22, 32'd1, 32'd1);
        tick();
        clr();
        chk("pre_reset_count", 32'(count), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_count", 32'(count), 0);
        chk("async_reset_stall", 32'(iq_stall), 0);
        tick();
        rst_n    = 1'b1;
        stall_in = 1'b0;
        repeat (3) tick();
        chk("final_count", 32'(count), 0);
        chk("scoreboard_empty", 32'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
